serial_to_parallel_rx: RTL

- Bit-serial receiver that collects a single-bit input stream into a WIDTH-bit parallel word, one bit per accepted cycle, LSB first.
- It is the fan-out counterpart to the gate library's reduction blocks: one line in, many lines out.
- Sits between a serial link (or a bit-serial ALU stage) and word-wide logic.
- Input side uses a valid/ready handshake; output side uses a valid/ready handshake with a one-word holding register, so a full shift register and a full holding register can coexist.

---
 rtl/serial_to_parallel_rx.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_to_parallel_rx.sv
// Bit-serial receiver: gathers an LSB-first bit stream into WIDTH-bit words.
// A one-word holding register decouples the shifter from the consumer.
module serial_to_parallel_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inBit,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outWord,
  output logic             outValid,
  input  logic             outReady,
  output logic [CNT_W-1:0] outCount
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  state_t           state;
  state_t           stateNxt;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shiftNxt;
  logic [WIDTH-1:0] wordNxt;
  logic             validNxt;
  logic [CNT_W-1:0] cntNxt;
  logic             accept;
  logic             holdFree;

  // Ready depends on state alone so no combinational path reaches it.
  assign inReady  = (state == FILL);
  assign accept   = inValid && inReady;
  // Holding register can take a word if empty or emptied this edge.
  assign holdFree = !outValid || outReady;

  // Next-state, shifter and holding-register update.
  always_comb begin
    stateNxt = state;
    shiftNxt = shiftReg;
    cntNxt   = outCount;
    wordNxt  = outWord;
    validNxt = outValid && !outReady;
    unique case (state)
      FILL: begin
        if (accept) begin
          shiftNxt = shiftReg | (WIDTH'(inBit) << outCount);
          if (outCount == LastCnt) begin
            if (holdFree) begin
              wordNxt  = shiftNxt;
              validNxt = 1'b1;
              shiftNxt = '0;
              cntNxt   = '0;
            end else begin
              cntNxt   = FullCnt;
              stateNxt = FULL;
            end
          end else begin
            cntNxt = outCount + OneCnt;
          end
        end
      end
      FULL: begin
        if (holdFree) begin
          wordNxt  = shiftReg;
          validNxt = 1'b1;
          shiftNxt = '0;
          cntNxt   = '0;
          stateNxt = FILL;
        end
      end
      default: stateNxt = FILL;
    endcase
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      shiftReg <= '0;
      outCount <= '0;
      outWord  <= '0;
      outValid <= 1'b0;
    end else begin
      state    <= stateNxt;
      shiftReg <= shiftNxt;
      outCount <= cntNxt;
      outWord  <= wordNxt;
      outValid <= validNxt;
    end
  end

endmodule
